// File: rtl/mipi_csi_pkg.sv
// Shared CSI-2 receive definitions: data types, header field offsets, decoder states
// and the header ECC helper used by mipi_rx_header_ecc.
package mipi_csi_pkg;

  localparam logic [5:0] DT_FS    = 6'h00;
  localparam logic [5:0] DT_FE    = 6'h01;
  localparam logic [5:0] DT_LS    = 6'h02;
  localparam logic [5:0] DT_LE    = 6'h03;
  localparam logic [5:0] DT_RAW8  = 6'h2A;
  localparam logic [5:0] DT_RAW10 = 6'h2B;

  localparam int HDR_DI_LSB  = 0;
  localparam int HDR_WC_LSB  = 8;
  localparam int HDR_ECC_LSB = 24;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PAYLOAD  = 2'd1,
    ST_WAIT_END = 2'd2
  } state_e;

  // CSI-2 Hamming parity over the 24 header data bits (DI, WC lsb, WC msb).
  function automatic logic [5:0] csi2_ecc(input logic [23:0] d);
    logic [5:0] p;
    p[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]^d[16]^d[20]^d[21]^d[22]^d[23];
    p[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]^d[17]^d[20]^d[21]^d[22]^d[23];
    p[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]^d[18]^d[20]^d[21]^d[22];
    p[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]^d[19]^d[20]^d[21]^d[23];
    p[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]^d[19]^d[20]^d[22]^d[23];
    p[5] = d[10]^d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]^d[18]^d[19]^d[21]^d[22]^d[23];
    return p;
  endfunction

endpackage

// File: rtl/mipi_rx_header_ecc.sv
// Combinational 6-bit CSI-2 header ECC generator over header bytes 0..2.
module mipi_rx_header_ecc
  import mipi_csi_pkg::*;
(
  input  logic [23:0] hdr_i,
  output logic [5:0]  ecc_o
);

  assign ecc_o = csi2_ecc(hdr_i);

endmodule

// File: rtl/mipi_rx_packet_decoder.sv
// CSI-2 packet decoder: header parse, short-packet events, long-packet payload with byte enables.
// Header ECC checking is enabled by defining MIPI_RX_ECC_CHECK_EN.
module mipi_rx_packet_decoder
  import mipi_csi_pkg::*;
#(
  parameter logic [15:0] MAX_WC  = 16'd8192,
  parameter logic [5:0]  DT_LONG = 6'h10
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        lane_valid_i,
  input  logic [31:0] lane_byte_i,
  output logic        frame_start_o,
  output logic        frame_end_o,
  output logic        line_start_o,
  output logic        line_end_o,
  output logic [1:0]  pkt_vc_o,
  output logic [5:0]  pkt_dt_o,
  output logic [15:0] pkt_wc_o,
  output logic        long_start_o,
  output logic        payload_valid_o,
  output logic [31:0] payload_o,
  output logic [3:0]  payload_be_o,
  output logic        payload_last_o,
  output logic        ecc_err_o,
  output logic        wc_err_o,
  output logic        trunc_err_o
);

  state_e      state_q, state_d;
  logic [15:0] rem_cnt_q, rem_cnt_d;
  logic        fs_q, fs_d, fe_q, fe_d, ls_q, ls_d, le_q, le_d;
  logic [1:0]  pkt_vc_q, pkt_vc_d;
  logic [5:0]  pkt_dt_q, pkt_dt_d;
  logic [15:0] pkt_wc_q, pkt_wc_d;
  logic        long_start_q, long_start_d;
  logic        pv_q, pv_d;
  logic [31:0] payload_q, payload_d;
  logic [3:0]  be_q, be_d;
  logic        last_q, last_d;
  logic        ecc_err_q, ecc_err_d;
  logic        wc_err_q, wc_err_d;
  logic        trunc_q, trunc_d;

  logic [1:0]  hdr_vc_s;
  logic [5:0]  hdr_dt_s;
  logic [15:0] hdr_wc_s;
  logic        ecc_ok_s;
  logic [2:0]  take_s;
  logic [3:0]  be_s;
  logic [15:0] rem_next_s;

  assign hdr_vc_s = lane_byte_i[HDR_DI_LSB+6 +: 2];
  assign hdr_dt_s = lane_byte_i[HDR_DI_LSB +: 6];
  assign hdr_wc_s = lane_byte_i[HDR_WC_LSB +: 16];

`ifdef MIPI_RX_ECC_CHECK_EN
  logic [5:0] calc_ecc_s;
  mipi_rx_header_ecc u_hdr_ecc (
    .hdr_i (lane_byte_i[23:0]),
    .ecc_o (calc_ecc_s)
  );
  // Top two bits of the ECC byte are reserved and deliberately not compared.
  assign ecc_ok_s = (calc_ecc_s == lane_byte_i[HDR_ECC_LSB +: 6]);
`else
  assign ecc_ok_s = 1'b1;
`endif

  assign take_s     = (rem_cnt_q >= 16'd4) ? 3'd4 : rem_cnt_q[2:0];
  assign rem_next_s = rem_cnt_q - {13'd0, take_s};

  // Byte-enable mask for the number of payload bytes still owed
  always_comb begin
    case (take_s)
      3'd1:    be_s = 4'h1;
      3'd2:    be_s = 4'h3;
      3'd3:    be_s = 4'h7;
      3'd4:    be_s = 4'hF;
      default: be_s = 4'h0;
    endcase
  end

  // Next-state and output decode
  always_comb begin
    state_d      = state_q;
    rem_cnt_d    = rem_cnt_q;
    fs_d         = 1'b0;
    fe_d         = 1'b0;
    ls_d         = 1'b0;
    le_d         = 1'b0;
    pkt_vc_d     = pkt_vc_q;
    pkt_dt_d     = pkt_dt_q;
    pkt_wc_d     = pkt_wc_q;
    long_start_d = 1'b0;
    pv_d         = 1'b0;
    payload_d    = 32'h0000_0000;
    be_d         = 4'h0;
    last_d       = 1'b0;
    ecc_err_d    = 1'b0;
    wc_err_d     = 1'b0;
    trunc_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (lane_valid_i) begin
          if (!ecc_ok_s) begin
            ecc_err_d = 1'b1;
            state_d   = ST_WAIT_END;
          end else if (hdr_dt_s < DT_LONG) begin
            pkt_vc_d = hdr_vc_s;
            pkt_dt_d = hdr_dt_s;
            pkt_wc_d = hdr_wc_s;
            state_d  = ST_WAIT_END;
            case (hdr_dt_s)
              DT_FS:   fs_d = 1'b1;
              DT_FE:   fe_d = 1'b1;
              DT_LS:   ls_d = 1'b1;
              DT_LE:   le_d = 1'b1;
              default: fs_d = 1'b0;
            endcase
          end else if (hdr_wc_s > MAX_WC) begin
            wc_err_d = 1'b1;
            state_d  = ST_WAIT_END;
          end else begin
            pkt_vc_d     = hdr_vc_s;
            pkt_dt_d     = hdr_dt_s;
            pkt_wc_d     = hdr_wc_s;
            long_start_d = 1'b1;
            rem_cnt_d    = hdr_wc_s;
            state_d      = (hdr_wc_s == 16'd0) ? ST_WAIT_END : ST_PAYLOAD;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PAYLOAD: begin
        if (lane_valid_i) begin
          pv_d      = 1'b1;
          payload_d = lane_byte_i;
          be_d      = be_s;
          rem_cnt_d = rem_next_s;
          if (rem_next_s == 16'd0) begin
            last_d  = 1'b1;
            state_d = ST_WAIT_END;
          end else begin
            state_d = ST_PAYLOAD;
          end
        end else begin
          trunc_d   = 1'b1;
          rem_cnt_d = 16'd0;
          state_d   = ST_IDLE;
        end
      end
      ST_WAIT_END: begin
        if (!lane_valid_i) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT_END;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        rem_cnt_d = 16'd0;
      end
    endcase
  end

  // State, counter and registered outputs
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q      <= ST_IDLE;
      rem_cnt_q    <= 16'd0;
      fs_q         <= 1'b0;
      fe_q         <= 1'b0;
      ls_q         <= 1'b0;
      le_q         <= 1'b0;
      pkt_vc_q     <= 2'd0;
      pkt_dt_q     <= 6'd0;
      pkt_wc_q     <= 16'd0;
      long_start_q <= 1'b0;
      pv_q         <= 1'b0;
      payload_q    <= 32'h0000_0000;
      be_q         <= 4'h0;
      last_q       <= 1'b0;
      ecc_err_q    <= 1'b0;
      wc_err_q     <= 1'b0;
      trunc_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      rem_cnt_q    <= rem_cnt_d;
      fs_q         <= fs_d;
      fe_q         <= fe_d;
      ls_q         <= ls_d;
      le_q         <= le_d;
      pkt_vc_q     <= pkt_vc_d;
      pkt_dt_q     <= pkt_dt_d;
      pkt_wc_q     <= pkt_wc_d;
      long_start_q <= long_start_d;
      pv_q         <= pv_d;
      payload_q    <= payload_d;
      be_q         <= be_d;
      last_q       <= last_d;
      ecc_err_q    <= ecc_err_d;
      wc_err_q     <= wc_err_d;
      trunc_q      <= trunc_d;
    end
  end

  assign frame_start_o   = fs_q;
  assign frame_end_o     = fe_q;
  assign line_start_o    = ls_q;
  assign line_end_o      = le_q;
  assign pkt_vc_o        = pkt_vc_q;
  assign pkt_dt_o        = pkt_dt_q;
  assign pkt_wc_o        = pkt_wc_q;
  assign long_start_o    = long_start_q;
  assign payload_valid_o = pv_q;
  assign payload_o       = payload_q;
  assign payload_be_o    = be_q;
  assign payload_last_o  = last_q;
  assign ecc_err_o       = ecc_err_q;
  assign wc_err_o        = wc_err_q;
  assign trunc_err_o     = trunc_q;

endmodule

// File: tb/tb_mipi_rx_packet_decoder.sv
// Directed plus randomized bench for mipi_rx_packet_decoder against a burst-level reference model.
// Builds with or without MIPI_RX_ECC_CHECK_EN; ECC-specific steps are included only when it is defined.
module tb_mipi_rx_packet_decoder;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        lane_valid_i;
  logic [31:0] lane_byte_i;
  logic        frame_start_o, frame_end_o, line_start_o, line_end_o;
  logic [1:0]  pkt_vc_o;
  logic [5:0]  pkt_dt_o;
  logic [15:0] pkt_wc_o;
  logic        long_start_o, payload_valid_o, payload_last_o;
  logic [31:0] payload_o;
  logic [3:0]  payload_be_o;
  logic        ecc_err_o, wc_err_o, trunc_err_o;

  int total = 0;
  int bad   = 0;

  logic [1:0]  m_vc = 2'd0;
  logic [5:0]  m_dt = 6'd0;
  logic [15:0] m_wc = 16'd0;
  logic [31:0] burst_q[$];

  always #5 clk_i = ~clk_i;

  mipi_rx_packet_decoder dut (
    .clk_i(clk_i), .reset_i(reset_i), .lane_valid_i(lane_valid_i), .lane_byte_i(lane_byte_i),
    .frame_start_o(frame_start_o), .frame_end_o(frame_end_o), .line_start_o(line_start_o),
    .line_end_o(line_end_o), .pkt_vc_o(pkt_vc_o), .pkt_dt_o(pkt_dt_o), .pkt_wc_o(pkt_wc_o),
    .long_start_o(long_start_o), .payload_valid_o(payload_valid_o), .payload_o(payload_o),
    .payload_be_o(payload_be_o), .payload_last_o(payload_last_o), .ecc_err_o(ecc_err_o),
    .wc_err_o(wc_err_o), .trunc_err_o(trunc_err_o)
  );

  // Each parity bit is the XOR of the header bits selected by its coverage mask.
  function automatic logic [5:0] ref_ecc(input logic [23:0] d);
    logic [23:0] m [6];
    logic [5:0]  e;
    m[0] = 24'hF12CB7; m[1] = 24'hF2555B; m[2] = 24'h749A6D;
    m[3] = 24'hB8E38E; m[4] = 24'hDF03F0; m[5] = 24'hEFFC00;
    for (int i = 0; i < 6; i++) e[i] = ^(d & m[i]);
    return e;
  endfunction

  function automatic logic [31:0] mk_hdr(input logic [1:0] vc, input logic [5:0] dt,
                                         input logic [15:0] wc, input bit corrupt);
    logic [23:0] d;
    logic [7:0]  b3;
    d = {wc, vc, dt};
`ifdef MIPI_RX_ECC_CHECK_EN
    b3 = {2'($urandom), ref_ecc(d) ^ (corrupt ? 6'(1 << $urandom_range(0, 5)) : 6'd0)};
`else
    b3 = 8'($urandom);
`endif
    return {b3, d};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] events();
    return {frame_start_o, frame_end_o, line_start_o, line_end_o, long_start_o,
            payload_valid_o, payload_last_o, ecc_err_o, wc_err_o, trunc_err_o};
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, "_ev"}, {18'd0, events(), payload_be_o}, 32'd0);
    chk({tag, "_pkt"}, {8'd0, pkt_vc_o, pkt_dt_o, pkt_wc_o}, 32'd0);
    chk({tag, "_pl"}, payload_o, 32'd0);
  endtask

  // ev bits: 9 FS, 8 FE, 7 LS, 6 LE, 5 long_start, 4 valid, 3 last, 2 ecc, 1 wc, 0 trunc
  task automatic step(input logic v, input logic [31:0] w, input logic [9:0] ev,
                      input logic [3:0] be, input logic [31:0] pl);
    logic [31:0] mask;
    lane_valid_i = v;
    lane_byte_i  = w;
    @(posedge clk_i);
    #1;
    chk("events", {22'd0, events()}, {22'd0, ev});
    chk("be", {28'd0, payload_be_o}, {28'd0, be});
    if (ev[4]) begin
      mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
      chk("payload", payload_o & mask, pl & mask);
    end
    chk("pkt", {8'd0, pkt_vc_o, pkt_dt_o, pkt_wc_o}, {8'd0, m_vc, m_dt, m_wc});
  endtask

  // Drive burst_q as one HS burst, then `idle` cycles with lane_valid_i low.
  task automatic run_burst(input int idle);
    logic [31:0] h;
    logic [9:0]  ev;
    logic [3:0]  be;
    logic [31:0] pl;
    bit          ecc_ok;
    int          wc, npw, nbytes;
    h      = burst_q[0];
    wc     = int'(h[23:8]);
    npw    = 0;
`ifdef MIPI_RX_ECC_CHECK_EN
    ecc_ok = (ref_ecc(h[23:0]) == h[29:24]);
`else
    ecc_ok = 1'b1;
`endif
    ev = 10'd0;
    if (!ecc_ok) ev[2] = 1'b1;
    else if (h[5:0] < 6'h10) begin
      m_vc = h[7:6]; m_dt = h[5:0]; m_wc = h[23:8];
      if (h[5:0] <= 6'd3) ev[9 - int'(h[5:0])] = 1'b1;
    end else if (wc > 8192) ev[1] = 1'b1;
    else begin
      m_vc = h[7:6]; m_dt = h[5:0]; m_wc = h[23:8];
      ev[5] = 1'b1;
      npw   = (wc + 3) / 4;
    end
    step(1'b1, h, ev, 4'h0, 32'd0);
    for (int k = 1; k < burst_q.size(); k++) begin
      ev = 10'd0; be = 4'h0; pl = 32'd0;
      if (k <= npw) begin
        nbytes = wc - 4 * (k - 1);
        if (nbytes > 4) nbytes = 4;
        be    = 4'((1 << nbytes) - 1);
        pl    = burst_q[k];
        ev[4] = 1'b1;
        ev[3] = (k == npw);
      end
      step(1'b1, burst_q[k], ev, be, pl);
    end
    for (int k = 0; k < idle; k++) begin
      ev = 10'd0;
      if (k == 0 && npw > burst_q.size() - 1) ev[0] = 1'b1;
      step(1'b0, $urandom, ev, 4'h0, 32'd0);
    end
  endtask

  initial begin
    logic [1:0]  vc;
    logic [5:0]  dt;
    logic [15:0] wc;
    int          r, npw, len;
    bit          corrupt;

    reset_i      = 1'b0;
    lane_valid_i = 1'b0;
    lane_byte_i  = 32'd0;
    #12;
    chk_zero("reset");
    @(posedge clk_i); #1;
    reset_i = 1'b1;
    step(1'b0, 32'hDEADBEEF, 10'd0, 4'h0, 32'd0);

    // Frame start, all-zero header (ECC of zero data is zero)
    burst_q = {}; burst_q.push_back(32'h00000000);
    run_burst(2);
    // RAW8 WC=6: full word then two-byte tail with CRC masked
    burst_q = {}; burst_q.push_back(32'h0000062A);
    burst_q.push_back(32'h44332211); burst_q.push_back(32'hCCCC6655);
    run_burst(2);
    // Long header with WC=0, trailing garbage ignored
    burst_q = {}; burst_q.push_back(32'h0000002B); burst_q.push_back(32'h12345678);
    run_burst(2);
    // WC=16 truncated after two payload words, then a clean FS burst
    burst_q = {}; burst_q.push_back(mk_hdr(2'd1, 6'h2A, 16'd16, 1'b0));
    burst_q.push_back(32'hA1A2A3A4); burst_q.push_back(32'hB1B2B3B4);
    run_burst(2);
    burst_q = {}; burst_q.push_back(mk_hdr(2'd3, 6'h00, 16'h0042, 1'b0));
    run_burst(1);
    // WC just above MAX_WC is dropped
    burst_q = {}; burst_q.push_back(mk_hdr(2'd0, 6'h2B, 16'd8193, 1'b0));
    burst_q.push_back(32'h55555555);
    run_burst(1);
`ifdef MIPI_RX_ECC_CHECK_EN
    burst_q = {}; burst_q.push_back(32'h01000000);
    run_burst(2);
`endif

    // Asynchronous reset in the middle of a payload
    burst_q = {}; burst_q.push_back(mk_hdr(2'd2, 6'h2A, 16'd16, 1'b0));
    burst_q.push_back(32'h01020304);
    lane_valid_i = 1'b1; lane_byte_i = burst_q[0];
    @(posedge clk_i); #1;
    lane_byte_i = burst_q[1];
    @(posedge clk_i); #1;
    chk("pre_rst_pv", {31'd0, payload_valid_o}, 32'd1);
    #2;
    reset_i = 1'b0;
    #1;
    chk_zero("midrst");
    m_vc = 2'd0; m_dt = 6'd0; m_wc = 16'd0;
    lane_valid_i = 1'b0;
    @(posedge clk_i); #1;
    reset_i = 1'b1;
    burst_q = {}; burst_q.push_back(32'h00000001);
    run_burst(2);

    // Randomized bursts
    for (int b = 0; b < 60; b++) begin
      vc = 2'($urandom_range(0, 3));
      r  = $urandom_range(0, 9);
      if (r <= 3)      dt = 6'(r);
      else if (r == 4) dt = 6'($urandom_range(4, 15));
      else if (r == 5) dt = 6'h2A;
      else if (r == 6) dt = 6'h2B;
      else             dt = 6'($urandom_range(16, 63));
      if (dt < 6'h10) wc = 16'($urandom);
      else begin
        r = $urandom_range(0, 19);
        if (r == 0)      wc = 16'd8192;
        else if (r == 1) wc = 16'($urandom_range(8193, 65535));
        else             wc = 16'($urandom_range(0, 40));
      end
      corrupt = ($urandom_range(0, 7) == 0);
      burst_q = {};
      burst_q.push_back(mk_hdr(vc, dt, wc, corrupt));
      npw = (dt >= 6'h10 && wc <= 16'd8192) ? (int'(wc) + 3) / 4 : 0;
      if (npw > 0 && $urandom_range(0, 4) == 0) len = $urandom_range(0, npw - 1);
      else len = npw + $urandom_range(0, 2);
      for (int k = 0; k < len; k++) burst_q.push_back($urandom);
      run_burst($urandom_range(1, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
